// File: rtl/tree_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tree_acc_ctrl
// Purpose  : Gates vectors into an external adder tree and integrates its
//            signed sums over cfg_len vectors.
// Option   : define TREE_ACC_SAT_EN to saturate the accumulator (default wraps)
// Revision : 1.0
// ============================================================================
module tree_acc_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PARALLEL   = 10,
  parameter int ACC_WIDTH  = 32,
  localparam int SW        = DATA_WIDTH + $clog2(PARALLEL)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [15:0]          cfg_len,
  input  logic                 din_valid,
  output logic                 tree_in_valid,
  input  logic [SW-1:0]        tree_dout,
  input  logic                 tree_out_valid,
  output logic [ACC_WIDTH-1:0] acc_dout,
  output logic                 acc_valid,
  output logic                 busy,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [15:0]            r_len;
  logic [15:0]            r_issue;
  logic [15:0]            r_recv;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic                   r_acc_valid;
  logic                   r_busy;
  logic                   r_ovf;

  logic                   w_accept;
  logic                   w_start_go;
  logic [15:0]            w_issue_nxt;
  logic [15:0]            w_recv_nxt;
  logic signed [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH-1:0]   w_sum;
  logic [ACC_WIDTH-1:0]   w_acc_nxt;
  logic                   w_ovf;

  assign tree_in_valid = (r_state == RUN) && din_valid;
  assign w_accept      = tree_out_valid && ((r_state == RUN) || (r_state == DRAIN));
  assign w_start_go    = (r_state == IDLE) && start;
  assign w_issue_nxt   = r_issue + 16'd1;
  assign w_recv_nxt    = r_recv + {15'd0, w_accept};

  assign w_ext = ACC_WIDTH'($signed(tree_dout));
  assign w_sum = r_acc + w_ext;
  // Signed overflow: operands share a sign that the sum does not.
  assign w_ovf = (r_acc[ACC_WIDTH-1] == w_ext[ACC_WIDTH-1]) &&
                 (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);

`ifdef TREE_ACC_SAT_EN
  assign w_acc_nxt = !w_ovf ? w_sum :
                     r_acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
  assign w_acc_nxt = w_sum;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (tree_in_valid && (w_issue_nxt == r_len)) w_state_nxt = DRAIN;
      // Also covers results that all arrived while still issuing.
      DRAIN:   if (w_recv_nxt == r_len) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_len       <= 16'd0;
      r_issue     <= 16'd0;
      r_recv      <= 16'd0;
      r_acc       <= '0;
      r_acc_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != IDLE);
      r_acc_valid <= (w_state_nxt == DONE);
      if (w_start_go) begin
        r_len   <= (cfg_len == 16'd0) ? 16'd1 : cfg_len;
        r_issue <= 16'd0;
        r_recv  <= 16'd0;
        r_acc   <= '0;
        r_ovf   <= 1'b0;
      end else begin
        if (tree_in_valid) r_issue <= w_issue_nxt;
        if (w_accept) begin
          r_recv <= w_recv_nxt;
          r_acc  <= w_acc_nxt;
          if (w_ovf) r_ovf <= 1'b1;
        end
      end
    end
  end

  assign acc_dout  = r_acc;
  assign acc_valid = r_acc_valid;
  assign busy      = r_busy;
  assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_tree_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tree_acc_ctrl
// Purpose  : Directed bench for tree_acc_ctrl; the adder tree is modelled by
//            driving tree_dout/tree_out_valid one cycle after each issue.
// Revision : 1.0
// ============================================================================
module tb_tree_acc_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, din_valid, tree_out_valid;
  logic [15:0] cfg_len;
  logic [11:0] tree_dout;

  logic        tiv_a, av_a, busy_a, ovf_a;
  logic [31:0] acc_a;
  logic        tiv_b, av_b, busy_b, ovf_b;
  logic [11:0] acc_b;

  int checks = 0;
  int errors = 0;
  int n_iss  = 0;
  int n_av   = 0;

  // Default build: SW = 8 + 4 = 12
  tree_acc_ctrl #(.DATA_WIDTH(8), .PARALLEL(10), .ACC_WIDTH(32)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .din_valid(din_valid), .tree_in_valid(tiv_a), .tree_dout(tree_dout),
    .tree_out_valid(tree_out_valid), .acc_dout(acc_a), .acc_valid(av_a),
    .busy(busy_a), .overflow(ovf_a)
  );

  // Narrow build: SW = 11 + 1 = 12 = ACC_WIDTH
  tree_acc_ctrl #(.DATA_WIDTH(11), .PARALLEL(2), .ACC_WIDTH(12)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .din_valid(din_valid), .tree_in_valid(tiv_b), .tree_dout(tree_dout),
    .tree_out_valid(tree_out_valid), .acc_dout(acc_b), .acc_valid(av_b),
    .busy(busy_b), .overflow(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, sample strobes at negedge, settle past posedge.
  task automatic cyc(input logic st, input logic dv, input logic tov, input logic [11:0] td);
    start          = st;
    din_valid      = dv;
    tree_out_valid = tov;
    tree_dout      = td;
    @(negedge clk);
    if (tiv_a) n_iss++;
    if (av_a)  n_av++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; din_valid = 1'b1; tree_out_valid = 1'b0;
    tree_dout = 12'd0; cfg_len = 16'd4;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tiv",   {31'd0, tiv_a},  32'd0);
    check("rst_busy",  {31'd0, busy_a}, 32'd0);
    check("rst_av",    {31'd0, av_a},   32'd0);
    check("rst_acc",   acc_a,           32'd0);
    check("rst_ovf",   {31'd0, ovf_a},  32'd0);
    rst_n = 1'b1;
    din_valid = 1'b0;

    // Basic integration: 10 + 20 - 5 + 7 = 32
    n_iss = 0; n_av = 0; cfg_len = 16'd4;
    cyc(1, 1, 0, 12'd0);
    check("run_busy",  {31'd0, busy_a}, 32'd1);
    check("start_noiss", n_iss, 32'd0);
    cyc(0, 1, 0, 12'd0);
    cyc(0, 1, 1, 12'd10);
    cyc(0, 1, 1, 12'd20);
    cyc(0, 1, 1, 12'hFFB);
    cyc(0, 1, 1, 12'd7);
    check("b_av",      {31'd0, av_a},   32'd1);
    check("b_acc",     acc_a,           32'd32);
    check("b_busy_done", {31'd0, busy_a}, 32'd1);
    check("b_issues",  n_iss,           32'd4);
    cyc(0, 0, 0, 12'd0);
    check("b_av_drop", {31'd0, av_a},   32'd0);
    check("b_busy_idle", {31'd0, busy_a}, 32'd0);
    check("b_acc_hold", acc_a,          32'd32);
    check("b_av_count", n_av,           32'd1);

    // cfg_len = 0 behaves as 1
    n_iss = 0; n_av = 0; cfg_len = 16'd0;
    cyc(1, 0, 0, 12'd0);
    cyc(0, 1, 0, 12'd0);
    cyc(0, 1, 1, 12'hFFD);
    check("z_acc",     acc_a,           32'hFFFF_FFFD);
    check("z_av",      {31'd0, av_a},   32'd1);
    check("z_ovf",     {31'd0, ovf_a},  32'd0);
    check("z_issues",  n_iss,           32'd1);
    cyc(0, 0, 0, 12'd0);

    // Gapped valid, restarts ignored in RUN, DRAIN and DONE
    n_iss = 0; n_av = 0; cfg_len = 16'd3;
    cyc(1, 1, 0, 12'd0);
    cyc(0, 1, 0, 12'd0);
    cyc(1, 0, 1, 12'd5);
    cyc(0, 1, 0, 12'd0);
    cyc(0, 0, 1, 12'd6);
    cyc(0, 1, 0, 12'd0);
    cyc(1, 0, 1, 12'd7);
    check("g_av",      {31'd0, av_a},   32'd1);
    check("g_acc",     acc_a,           32'd18);
    cyc(1, 0, 0, 12'd0);
    check("g_busy_idle", {31'd0, busy_a}, 32'd0);
    cyc(0, 0, 0, 12'd0);
    check("g_no_restart", {31'd0, busy_a}, 32'd0);
    check("g_issues",  n_iss,           32'd3);
    check("g_av_count", n_av,           32'd1);

    // Asynchronous reset while draining
    n_iss = 0; n_av = 0; cfg_len = 16'd4;
    cyc(1, 0, 0, 12'd0);
    cyc(0, 1, 0, 12'd0);
    cyc(0, 1, 0, 12'd0);
    cyc(0, 1, 1, 12'd3);
    cyc(0, 1, 1, 12'd4);
    check("r_busy_drain", {31'd0, busy_a}, 32'd1);
    check("r_acc_part", acc_a,          32'd7);
    #1 rst_n = 1'b0;
    #1;
    check("r_busy",    {31'd0, busy_a}, 32'd0);
    check("r_acc",     acc_a,           32'd0);
    check("r_av",      {31'd0, av_a},   32'd0);
    #1 rst_n = 1'b1;
    cyc(0, 0, 1, 12'd9);
    cyc(0, 0, 1, 12'd9);
    check("r_ignored_acc", acc_a,       32'd0);
    check("r_ignored_busy", {31'd0, busy_a}, 32'd0);
    check("r_no_av",   n_av,            32'd0);

    // Narrow accumulator overflow: 2047 + 2047
    n_iss = 0; n_av = 0; cfg_len = 16'd2;
    cyc(1, 0, 0, 12'd0);
    cyc(0, 1, 0, 12'd0);
    cyc(0, 1, 1, 12'h7FF);
    cyc(0, 0, 1, 12'h7FF);
    check("o_ovf",     {31'd0, ovf_b},  32'd1);
`ifdef TREE_ACC_SAT_EN
    check("o_acc",     {20'd0, acc_b},  32'h7FF);
`else
    check("o_acc",     {20'd0, acc_b},  32'hFFE);
`endif
    check("o_av",      {31'd0, av_b},   32'd1);
    check("o_wide_acc", acc_a,          32'd4094);
    check("o_wide_ovf", {31'd0, ovf_a}, 32'd0);
    cyc(0, 0, 0, 12'd0);
    check("o_ovf_hold", {31'd0, ovf_b}, 32'd1);
    cyc(1, 0, 0, 12'd0);
    check("o_ovf_clr", {31'd0, ovf_b},  32'd0);
    check("o_acc_clr", {20'd0, acc_b},  32'd0);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;

    // Maximum length, no counter wrap
    n_iss = 0; n_av = 0; cfg_len = 16'hFFFF;
    cyc(1, 0, 0, 12'd0);
    for (int i = 1; i <= 65535; i++) cyc(0, 1, (i > 1), 12'd1);
    cyc(0, 0, 1, 12'd1);
    check("m_acc",     acc_a,           32'd65535);
    check("m_av",      {31'd0, av_a},   32'd1);
    check("m_issues",  n_iss,           32'd65535);
    check("m_ovf",     {31'd0, ovf_a},  32'd0);
    cyc(0, 0, 0, 12'd0);
    check("m_av_count", n_av,           32'd1);
    check("m_busy",    {31'd0, busy_a}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
